// File: rtl/bytecode_loader.sv
// ============================================================================
//  Module   : bytecode_loader
//  Purpose  : Fills byte-wide program memory from a valid/ready stream,
//             appends the HALT opcode, enables the processor and captures
//             its final result. Optional checksum via
//             BYTECODE_LOADER_CHECKSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bytecode_loader #(
    parameter int          DEPTH = 1024,
    parameter int          AW    = 10,
    parameter logic [7:0]  HALT  = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          enable,
    input  logic          running,
    input  logic [7:0]    result,
    input  logic          restart,
    output logic          done,
    output logic [7:0]    final_result,
    output logic          overflow,
    output logic [AW:0]   byte_count,
    output logic [7:0]    checksum
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_TERM  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ptr_one   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_cnt_one   = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_byte_count;
    logic [7:0]    r_final_result;
    logic          r_overflow;
    logic          w_room;
    logic          w_accept;
    logic          w_ovf_hit;
    logic          w_capture;
    logic          w_clear;

    // The last address is reserved for HALT, so the stream stalls one short.
    assign w_room = (r_ptr != c_last_addr);

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        enable    = 1'b0;
        w_accept  = 1'b0;
        w_ovf_hit = 1'b0;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready  = w_room;
                w_accept  = in_valid & w_room;
                mem_we    = w_accept;
                mem_wdata = in_data;
                if (w_accept && in_last) begin
                    w_next = S_TERM;
                end else if (in_valid && !w_room) begin
                    w_next    = S_ERR;
                    w_ovf_hit = 1'b1;
                end
            end
            S_TERM: begin
                mem_we    = 1'b1;
                mem_wdata = HALT;
                w_next    = S_START;
            end
            S_START: begin
                enable = 1'b1;
                if (running) w_next = S_RUN;
            end
            S_RUN: begin
                enable = 1'b1;
                if (!running) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end
            end
            S_DONE: begin
                enable = 1'b1;
                if (restart) begin
                    w_next  = S_LOAD;
                    w_clear = 1'b1;
                end
            end
            S_ERR: begin
                if (restart) begin
                    w_next  = S_LOAD;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_LOAD;
            r_ptr          <= '0;
            r_byte_count   <= '0;
            r_final_result <= 8'h00;
            r_overflow     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_ptr          <= '0;
                r_byte_count   <= '0;
                r_final_result <= 8'h00;
                r_overflow     <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_ptr        <= r_ptr + c_ptr_one;
                    r_byte_count <= r_byte_count + c_cnt_one;
                end
                if (w_ovf_hit) r_overflow     <= 1'b1;
                if (w_capture) r_final_result <= result;
            end
        end
    end

`ifdef BYTECODE_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_checksum <= 8'h00;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

    assign mem_addr     = r_ptr;
    assign done         = (r_state == S_DONE);
    assign final_result = r_final_result;
    assign overflow     = r_overflow;
    assign byte_count   = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_bytecode_loader.sv
// ============================================================================
//  Module   : tb_bytecode_loader
//  Purpose  : Self-checking bench for bytecode_loader (DEPTH=8 instance),
//             table-driven main flow plus hand-written corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bytecode_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          enable;
    logic          running;
    logic [7:0]    result;
    logic          restart;
    logic          done;
    logic [7:0]    final_result;
    logic          overflow;
    logic [AW:0]   byte_count;
    logic [7:0]    checksum;

    bytecode_loader #(.DEPTH(DEPTH), .AW(AW), .HALT(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .enable(enable), .running(running), .result(result), .restart(restart),
        .done(done), .final_result(final_result), .overflow(overflow),
        .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Program memory as the processor would see it, plus a write counter.
    logic [7:0] mem [DEPTH];
    int         wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v;     logic [7:0] d;   logic l;
        logic       run;   logic [7:0] res; logic rs;
        logic       e_rdy; logic e_we;      logic [AW-1:0] e_addr; logic [7:0] e_wd;
        logic       e_en;  logic e_done;    logic [AW:0] e_cnt;
        logic [7:0] e_fr;  logic [7:0] e_ck;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic l,
                                input logic run, input logic [7:0] res, input logic rs,
                                input logic e_rdy, input logic e_we, input logic [AW-1:0] e_addr,
                                input logic [7:0] e_wd, input logic e_en, input logic e_done,
                                input logic [AW:0] e_cnt, input logic [7:0] e_fr, input logic [7:0] e_ck);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.run = run; t.res = res; t.rs = rs;
        t.e_rdy = e_rdy; t.e_we = e_we; t.e_addr = e_addr; t.e_wd = e_wd;
        t.e_en = e_en; t.e_done = e_done; t.e_cnt = e_cnt; t.e_fr = e_fr; t.e_ck = e_ck;
        vecs.push_back(t);
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic run, input logic [7:0] res, input logic rs);
        in_valid = v; in_data = d; in_last = l;
        running = run; result = res; restart = rs;
    endtask

    // Optional idle gap, then one accepted byte; leaves valid low afterwards.
    task automatic send(input logic [7:0] d, input logic last, input int gap, input int addr);
        for (int g = 0; g < gap; g++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            #1 chk("gap_no_write", {31'd0, mem_we}, 32'd0);
            @(negedge clk);
        end
        drive(1'b1, d, last, 1'b0, 8'h00, 1'b0);
        #1;
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        chk("send_addr", {29'd0, mem_addr}, addr);
        chk("send_wdata", {24'd0, mem_wdata}, {24'd0, d});
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int w0;
        logic [7:0] sum;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_en", {31'd0, enable}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_cnt", {28'd0, byte_count}, 32'd0);
        chk("rst_ck", {24'd0, checksum}, 32'd0);
        chk("rst_fr", {24'd0, final_result}, 32'd0);
        rst = 1'b0;

        // Main flow: 01,02,03 load, 10-cycle run, result capture, restart
        add(1, 8'h01, 0, 0, 8'h00, 0,  1, 1, 3'd0, 8'h01, 0, 0, 4'd0, 8'h00, 8'h00);
        add(1, 8'h02, 0, 0, 8'h00, 0,  1, 1, 3'd1, 8'h02, 0, 0, 4'd1, 8'h00, 8'h01);
        add(1, 8'h03, 1, 0, 8'h00, 0,  1, 1, 3'd2, 8'h03, 0, 0, 4'd2, 8'h00, 8'h03);
        add(0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 3'd3, 8'hFF, 0, 0, 4'd3, 8'h00, 8'h06);
        add(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 3'd3, 8'h00, 1, 0, 4'd3, 8'h00, 8'h06);
        add(0, 8'h00, 0, 1, 8'h00, 0,  0, 0, 3'd3, 8'h00, 1, 0, 4'd3, 8'h00, 8'h06);
        for (int k = 0; k < 9; k++)
            add(0, 8'h00, 0, 1, 8'h00, (k == 0), 0, 0, 3'd3, 8'h00, 1, 0, 4'd3, 8'h00, 8'h06);
        add(0, 8'h00, 0, 0, 8'h2A, 0,  0, 0, 3'd3, 8'h00, 1, 0, 4'd3, 8'h00, 8'h06);
        add(1, 8'h99, 0, 0, 8'h55, 0,  0, 0, 3'd3, 8'h00, 1, 1, 4'd3, 8'h2A, 8'h06);
        add(0, 8'h00, 0, 0, 8'h55, 1,  0, 0, 3'd3, 8'h00, 1, 1, 4'd3, 8'h2A, 8'h06);
        add(0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].run, vecs[i].res, vecs[i].rs);
            #1;
            chk($sformatf("row%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("row%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("row%0d_addr", i), {29'd0, mem_addr}, {29'd0, vecs[i].e_addr});
            if (vecs[i].e_we)
                chk($sformatf("row%0d_wdata", i), {24'd0, mem_wdata}, {24'd0, vecs[i].e_wd});
            chk($sformatf("row%0d_en", i), {31'd0, enable}, {31'd0, vecs[i].e_en});
            chk($sformatf("row%0d_done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
            chk($sformatf("row%0d_cnt", i), {28'd0, byte_count}, {28'd0, vecs[i].e_cnt});
            chk($sformatf("row%0d_fr", i), {24'd0, final_result}, {24'd0, vecs[i].e_fr});
            chk($sformatf("row%0d_ck", i), {24'd0, checksum}, CK_EN ? {24'd0, vecs[i].e_ck} : 32'd0);
            @(negedge clk);
        end
        chk("img0", {24'd0, mem[0]}, 32'h01);
        chk("img1", {24'd0, mem[1]}, 32'h02);
        chk("img2", {24'd0, mem[2]}, 32'h03);
        chk("img3", {24'd0, mem[3]}, 32'hFF);

        // Same program with valid gaps of 1..3 cycles
        w0 = wr_cnt;
        send(8'h01, 1'b0, 1, 0);
        send(8'h02, 1'b0, 2, 1);
        send(8'h03, 1'b1, 3, 2);
        #1;
        chk("gap_term_we", {31'd0, mem_we}, 32'd1);
        chk("gap_term_addr", {29'd0, mem_addr}, 32'd3);
        chk("gap_term_wd", {24'd0, mem_wdata}, 32'hFF);
        @(negedge clk);
        chk("gap_en", {31'd0, enable}, 32'd1);
        chk("gap_cnt", {28'd0, byte_count}, 32'd3);
        chk("gap_writes", wr_cnt - w0, 32'd4);
        chk("gap_img3", {24'd0, mem[3]}, 32'hFF);

        // One-cycle running pulse: RUN lasts exactly one cycle
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 1'b0);
        #1 chk("pulse_run_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("pulse_done", {31'd0, done}, 32'd1);
        chk("pulse_fr", {24'd0, final_result}, 32'h77);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Overflow: 7 bytes fill 0..6, the 8th is refused
        w0 = wr_cnt;
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b0, 0, i);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("ovf_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        #1;
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_en", {31'd0, enable}, 32'd0);
        chk("ovf_err_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_err_we", {31'd0, mem_we}, 32'd0);
        chk("ovf_cnt", {28'd0, byte_count}, 32'd7);
        sum = 8'h85;
        chk("ovf_ck", {24'd0, checksum}, CK_EN ? {24'd0, sum} : 32'd0);
        @(negedge clk);
        chk("ovf_writes", wr_cnt - w0, 32'd7);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_restart_flag", {31'd0, overflow}, 32'd0);
        chk("ovf_restart_cnt", {28'd0, byte_count}, 32'd0);
        chk("ovf_restart_ready", {31'd0, in_ready}, 32'd1);

        // Maximum program: 7 bytes, in_last on the 7th, HALT at DEPTH-1
        for (int i = 0; i < 7; i++) send(8'h30 + 8'(i), (i == 6), 0, i);
        #1;
        chk("max_term_we", {31'd0, mem_we}, 32'd1);
        chk("max_term_addr", {29'd0, mem_addr}, 32'd7);
        chk("max_term_wd", {24'd0, mem_wdata}, 32'hFF);
        @(negedge clk);
        chk("max_en", {31'd0, enable}, 32'd1);
        chk("max_img7", {24'd0, mem[7]}, 32'hFF);
        chk("max_img6", {24'd0, mem[6]}, 32'h36);
        chk("max_cnt", {28'd0, byte_count}, 32'd7);

        // Reset in RUN
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        chk("run_en", {31'd0, enable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rstrun_en", {31'd0, enable}, 32'd0);
        chk("rstrun_ready", {31'd0, in_ready}, 32'd1);
        chk("rstrun_cnt", {28'd0, byte_count}, 32'd0);
        chk("rstrun_addr", {29'd0, mem_addr}, 32'd0);
        chk("rstrun_ck", {24'd0, checksum}, 32'd0);

        // Reset after two bytes of a load
        send(8'h21, 1'b0, 0, 0);
        send(8'h22, 1'b0, 0, 1);
        chk("mid_cnt", {28'd0, byte_count}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_cnt", {28'd0, byte_count}, 32'd0);
        chk("rstmid_addr", {29'd0, mem_addr}, 32'd0);
        chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid_ck", {24'd0, checksum}, 32'd0);

        // Fresh one-byte program
        send(8'h10, 1'b1, 0, 0);
        #1;
        chk("fresh_term_addr", {29'd0, mem_addr}, 32'd1);
        chk("fresh_term_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        chk("fresh_img0", {24'd0, mem[0]}, 32'h10);
        chk("fresh_img1", {24'd0, mem[1]}, 32'hFF);
        chk("fresh_en", {31'd0, enable}, 32'd1);
        chk("fresh_ck", {24'd0, checksum}, CK_EN ? 32'h10 : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
